morse_tick_scheduler: RTL and testbench

- Generates every timing strobe the Morse decoder needs from the 50 MHz system clock, as single-cycle clock enables rather than derived clocks.
- Provides three strobes:
  - a 25 MHz pixel enable for the display path;
  - a 1 ms tick;
  - a programmable Morse "unit" tick, used as the dot-length time base.
- Accepts runtime unit-length changes through a load/ack handshake and applies each change only on a unit boundary, so no partial unit is ever produced.

---
 rtl/morse_timing_pkg.sv | 30 +++
 rtl/morse_tick_scheduler_tick_counter.sv | 47 ++++
 rtl/morse_tick_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_morse_tick_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_timing_pkg.sv
// -----------------------------------------------------------------------------
// morse_timing_pkg
// Shared timing constants and scheduler state encoding for the Morse decoder
// timing path. Imported by the scheduler top and its counter sub-module.
// -----------------------------------------------------------------------------
package morse_timing_pkg;

  // System clock frequency the strobes are derived from.
  localparam int unsigned CLK_HZ      = 50_000_000;

  // Default system clocks per 1 ms tick.
  localparam int unsigned DEF_MS_DIV  = CLK_HZ / 1000;

  // Default width of the unit-length field (ms).
  localparam int unsigned DEF_UNIT_W  = 10;

  // Default unit length in ms after reset.
  localparam int unsigned DEF_UNIT_MS = 100;

  // Scheduler control states.
  //   IDLE : en low, counters cleared, unit loads applied immediately
  //   RUN  : strobes running, no unit change outstanding
  //   PEND : strobes running, a new unit length waits for the next boundary
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } sched_state_e;

endpackage : morse_timing_pkg

// File: rtl/morse_tick_scheduler_tick_counter.sv
// -----------------------------------------------------------------------------
// tick_counter
// Modulo-N counter with advance enable, synchronous clear and a wrap pulse.
// The modulus is given at runtime as its last value (N-1). Passing N-1 rather
// than N means the compare value always fits in WIDTH bits.
//
// Ports:
//   clk     in   1      clock
//   rst_n   in   1      asynchronous active-low reset
//   i_en    in   1      advance the counter this cycle
//   i_clr   in   1      synchronous clear (wins over i_en)
//   i_last  in   WIDTH  terminal count (modulus - 1)
//   o_wrap  out  1      combinational: counter is at i_last and advancing,
//                       so it returns to 0 on this edge
// -----------------------------------------------------------------------------
module tick_counter
  import morse_timing_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_last,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == i_last);
  assign o_wrap    = i_en & ~i_clr & w_at_last;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + WIDTH'(1);
    end
  end

endmodule : tick_counter

// File: rtl/morse_tick_scheduler.sv
// -----------------------------------------------------------------------------
// morse_tick_scheduler
// Produces the single-cycle clock enables used by the Morse decoder:
//   - pix_en    : 25 MHz pixel enable (every 2nd clock)
//   - ms_tick   : one pulse every MS_DIV clocks
//   - unit_tick : one pulse every unit_ms_cur ms ticks (dot-length base)
// A new unit length is requested with unit_load. While idle it is applied at
// once; while running it is held pending and applied on the next unit
// boundary, so a unit is never cut short or stretched mid-way.
//
// Ports:
//   clk_in       in   1       50 MHz system clock
//   rst          in   1       asynchronous active-low reset
//   en           in   1       run enable; 0 clears counters and idles
//   unit_ms_in   in   UNIT_W  requested unit length in ms (0 treated as 1)
//   unit_load    in   1       1-cycle load request for unit_ms_in
//   unit_ack     out  1       1-cycle pulse: requested length now in effect
//   pix_en       out  1       pixel enable, high every 2nd clock
//   ms_tick      out  1       1-cycle pulse every MS_DIV clocks
//   unit_tick    out  1       1-cycle pulse every unit_ms_cur ms ticks
//   unit_ms_cur  out  UNIT_W  unit length currently in effect
// All outputs are registered.
// -----------------------------------------------------------------------------
module morse_tick_scheduler
  import morse_timing_pkg::*;
#(
  parameter int unsigned MS_DIV       = DEF_MS_DIV,
  parameter int unsigned UNIT_W       = DEF_UNIT_W,
  parameter int unsigned UNIT_DEFAULT = DEF_UNIT_MS
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [UNIT_W-1:0] unit_ms_in,
  input  logic              unit_load,
  output logic              unit_ack,
  output logic              pix_en,
  output logic              ms_tick,
  output logic              unit_tick,
  output logic [UNIT_W-1:0] unit_ms_cur
);

  localparam int unsigned      MS_W    = $clog2(MS_DIV);
  localparam logic [MS_W-1:0]  MS_LAST = MS_W'(MS_DIV - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  sched_state_e      r_state;
  logic              r_phase;
  logic              r_pix_en;
  logic              r_ms_tick;
  logic              r_unit_tick;
  logic              r_unit_ack;
  logic              r_ack_dly;      // boundary apply: ack follows one cycle later
  logic [UNIT_W-1:0] r_unit_ms_cur;
  logic [UNIT_W-1:0] r_pend_ms;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  sched_state_e      w_state_nxt;
  logic              w_ms_wrap;
  logic              w_unit_wrap;
  logic [UNIT_W-1:0] w_unit_last;
  logic [UNIT_W-1:0] w_load_val;
  logic              w_cur_we;
  logic [UNIT_W-1:0] w_cur_val;
  logic              w_pend_we;
  logic              w_ack_now;
  logic              w_ack_later;

  // A zero-length unit would never wrap; treat it as the shortest legal unit.
  assign w_load_val  = (unit_ms_in == '0) ? UNIT_W'(1) : unit_ms_in;

  // unit_ms_cur is never 0, so the terminal count cannot underflow.
  assign w_unit_last = r_unit_ms_cur - UNIT_W'(1);

  // ---------------------------------------------------------------------------
  // ms divider: advances every clock while enabled.
  // ---------------------------------------------------------------------------
  tick_counter #(
    .WIDTH (MS_W)
  ) u_ms_cnt (
    .clk    (clk_in),
    .rst_n  (rst),
    .i_en   (en),
    .i_clr  (~en),
    .i_last (MS_LAST),
    .o_wrap (w_ms_wrap)
  );

  // ---------------------------------------------------------------------------
  // unit divider: advances on each ms wrap, so its wrap always coincides with
  // an ms wrap. The modulus only changes on a wrap (counter already 0) or
  // while cleared, so the counter never sits above the terminal count.
  // ---------------------------------------------------------------------------
  tick_counter #(
    .WIDTH (UNIT_W)
  ) u_unit_cnt (
    .clk    (clk_in),
    .rst_n  (rst),
    .i_en   (w_ms_wrap),
    .i_clr  (~en),
    .i_last (w_unit_last),
    .o_wrap (w_unit_wrap)
  );

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and load/apply decisions
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_we    = 1'b0;
    w_cur_val   = r_pend_ms;
    w_pend_we   = 1'b0;
    w_ack_now   = 1'b0;
    w_ack_later = 1'b0;

    case (r_state)
      IDLE: begin
        // Nothing is running, so a new length can take effect at once.
        if (unit_load) begin
          w_cur_we  = 1'b1;
          w_cur_val = w_load_val;
          w_ack_now = 1'b1;
        end
        if (en) begin
          w_state_nxt = RUN;
        end
      end

      RUN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          if (unit_load) begin
            w_cur_we  = 1'b1;
            w_cur_val = w_load_val;
            w_ack_now = 1'b1;
          end
        end else if (unit_load) begin
          // A load on the boundary edge itself also lands here and waits for
          // the following boundary.
          w_pend_we   = 1'b1;
          w_state_nxt = PEND;
        end
      end

      PEND: begin
        if (!en) begin
          // Stopping: flush the outstanding length immediately.
          w_state_nxt = IDLE;
          w_cur_we    = 1'b1;
          w_cur_val   = unit_load ? w_load_val : r_pend_ms;
          w_ack_now   = 1'b1;
        end else if (unit_load) begin
          // Newer request replaces the pending one, including on a boundary
          // edge; only the last value is ever acknowledged.
          w_pend_we = 1'b1;
        end else if (w_unit_wrap) begin
          w_cur_we    = 1'b1;
          w_cur_val   = r_pend_ms;
          w_ack_later = 1'b1;
          w_state_nxt = RUN;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Strobe and unit-length registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_phase       <= 1'b0;
      r_pix_en      <= 1'b0;
      r_ms_tick     <= 1'b0;
      r_unit_tick   <= 1'b0;
      r_unit_ack    <= 1'b0;
      r_ack_dly     <= 1'b0;
      r_unit_ms_cur <= UNIT_W'(UNIT_DEFAULT);
      r_pend_ms     <= '0;
    end else begin
      // Phase toggles while enabled and restarts from 0 whenever en drops,
      // so the first pix_en lands on the 2nd clock after en rises.
      r_phase     <= en & ~r_phase;
      r_pix_en    <= en & r_phase;
      r_ms_tick   <= w_ms_wrap;
      r_unit_tick <= w_unit_wrap;
      r_ack_dly   <= w_ack_later;
      r_unit_ack  <= w_ack_now | r_ack_dly;
      if (w_cur_we) begin
        r_unit_ms_cur <= w_cur_val;
      end
      if (w_pend_we) begin
        r_pend_ms <= w_load_val;
      end
    end
  end

  assign pix_en      = r_pix_en;
  assign ms_tick     = r_ms_tick;
  assign unit_tick   = r_unit_tick;
  assign unit_ack    = r_unit_ack;
  assign unit_ms_cur = r_unit_ms_cur;

endmodule : morse_tick_scheduler

// File: tb/tb_morse_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_morse_tick_scheduler
// Directed bench for morse_tick_scheduler with MS_DIV=4, UNIT_DEFAULT=3.
// Before each phase the expected per-cycle outputs are queued; every clock the
// front entry is popped and compared against the DUT on the falling edge.
// Cycle k of a phase is the k-th rising edge after that phase's stimulus.
// -----------------------------------------------------------------------------
module tb_morse_tick_scheduler;

  localparam int unsigned MS_DIV       = 4;
  localparam int unsigned UNIT_W       = 10;
  localparam int unsigned UNIT_DEFAULT = 3;

  // strb bit order: {pix_en, ms_tick, unit_tick, unit_ack}
  localparam int B_UNIT = 1;
  localparam int B_ACK  = 0;

  typedef struct packed {
    logic [15:0]       k;
    logic [3:0]        strb;
    logic              chk_cur;
    logic [UNIT_W-1:0] cur;
  } exp_t;

  logic              clk_in;
  logic              rst;
  logic              en;
  logic [UNIT_W-1:0] unit_ms_in;
  logic              unit_load;
  logic              unit_ack;
  logic              pix_en;
  logic              ms_tick;
  logic              unit_tick;
  logic [UNIT_W-1:0] unit_ms_cur;

  exp_t  exp_q[$];
  string scen;
  int    n_chk;
  int    n_err;

  morse_tick_scheduler #(
    .MS_DIV       (MS_DIV),
    .UNIT_W       (UNIT_W),
    .UNIT_DEFAULT (UNIT_DEFAULT)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .unit_ms_in  (unit_ms_in),
    .unit_load   (unit_load),
    .unit_ack    (unit_ack),
    .pix_en      (pix_en),
    .ms_tick     (ms_tick),
    .unit_tick   (unit_tick),
    .unit_ms_cur (unit_ms_cur)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue n running cycles: pix_en on even k, ms_tick every MS_DIV clocks.
  task automatic plan(input int n, input string tag, input int cur);
    exp_t e;
    scen = tag;
    for (int k = 1; k <= n; k++) begin
      e.k       = 16'(k);
      e.strb    = {((k % 2) == 0), ((k % MS_DIV) == 0), 1'b0, 1'b0};
      e.chk_cur = 1'b1;
      e.cur     = UNIT_W'(cur);
      exp_q.push_back(e);
    end
  endtask

  // Queue n idle cycles: no strobes at all.
  task automatic plan_idle(input int n, input string tag, input int cur);
    exp_t e;
    scen = tag;
    for (int k = 1; k <= n; k++) begin
      e.k       = 16'(k);
      e.strb    = 4'b0000;
      e.chk_cur = 1'b1;
      e.cur     = UNIT_W'(cur);
      exp_q.push_back(e);
    end
  endtask

  task automatic mark(input int k, input int bitpos);
    exp_t e;
    e = exp_q[k-1];
    e.strb[bitpos] = 1'b1;
    exp_q[k-1] = e;
  endtask

  task automatic cur_from(input int k, input int cur);
    exp_t e;
    for (int i = k - 1; i < exp_q.size(); i++) begin
      e = exp_q[i];
      e.chk_cur = 1'b1;
      e.cur     = UNIT_W'(cur);
      exp_q[i]  = e;
    end
  endtask

  task automatic no_cur(input int k);
    exp_t e;
    e = exp_q[k-1];
    e.chk_cur = 1'b0;
    exp_q[k-1] = e;
  endtask

  // One clock: let the edge happen, then compare on the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk_in);
    @(negedge clk_in);
    if (exp_q.size() == 0) begin
      check({scen, ".queue_underrun"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s.k%0d.strobes", scen, e.k),
            32'({pix_en, ms_tick, unit_tick, unit_ack}), 32'(e.strb));
      if (e.chk_cur) begin
        check($sformatf("%s.k%0d.unit_ms_cur", scen, e.k),
              32'(unit_ms_cur), 32'(e.cur));
      end
    end
  endtask

  task automatic load_step(input int val);
    unit_ms_in = UNIT_W'(val);
    unit_load  = 1'b1;
    step();
    unit_load  = 1'b0;
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    scen       = "reset";
    rst        = 1'b0;
    en         = 1'b0;
    unit_ms_in = '0;
    unit_load  = 1'b0;

    // Reset state
    #23;
    check("reset.strobes", 32'({pix_en, ms_tick, unit_tick, unit_ack}), 32'd0);
    check("reset.unit_ms_cur", 32'(unit_ms_cur), 32'(UNIT_DEFAULT));
    @(negedge clk_in);
    rst = 1'b1;
    plan_idle(2, "post_reset", 3);
    step(); step();

    // Free run with the default unit of 3 ms
    en = 1'b1;
    plan(26, "run_default", 3);
    mark(12, B_UNIT); mark(24, B_UNIT);
    repeat (26) step();
    en = 1'b0;
    plan_idle(2, "stop_default", 3);
    step(); step();

    // Idle load of 5: immediate ack, then units of 20 clocks
    plan_idle(4, "idle_load5", 3);
    mark(2, B_ACK); cur_from(2, 5);
    step(); load_step(5); step(); step();
    en = 1'b1;
    plan(21, "run_unit5", 5);
    mark(20, B_UNIT);
    repeat (21) step();
    en = 1'b0;
    plan_idle(1, "stop_unit5", 5);
    step();

    // Running load of 2 at clock 5: old length finishes, ack after boundary
    plan_idle(2, "set3_a", 3);
    mark(1, B_ACK);
    load_step(3); step();
    en = 1'b1;
    plan(21, "run_load2", 3);
    mark(12, B_UNIT); mark(20, B_UNIT); mark(13, B_ACK);
    cur_from(13, 2); no_cur(12);
    repeat (4) step(); load_step(2); repeat (16) step();
    en = 1'b0;
    plan_idle(1, "stop_load2", 2);
    step();

    // Loads 7 then 2 while pending, then a load on the boundary edge
    plan_idle(2, "set3_b", 3);
    mark(1, B_ACK);
    load_step(3); step();
    en = 1'b1;
    plan(49, "run_pend", 3);
    mark(12, B_UNIT); mark(20, B_UNIT); mark(28, B_UNIT); mark(48, B_UNIT);
    mark(13, B_ACK); mark(29, B_ACK);
    cur_from(13, 2); no_cur(12); cur_from(29, 5); no_cur(28);
    step(); load_step(7); repeat (3) step(); load_step(2);
    repeat (13) step(); load_step(5); repeat (29) step();
    en = 1'b0;
    plan_idle(1, "stop_pend", 5);
    step();

    // Load of 0 clamps to 1: unit_tick with every ms_tick
    plan_idle(2, "idle_load0", 1);
    mark(1, B_ACK);
    load_step(0); step();
    en = 1'b1;
    plan(13, "run_unit1", 1);
    mark(4, B_UNIT); mark(8, B_UNIT); mark(12, B_UNIT);
    repeat (13) step();
    en = 1'b0;
    plan_idle(1, "stop_unit1", 1);
    step();

    // en falls while a load is pending: applied and acked at once
    plan_idle(2, "set4", 4);
    mark(1, B_ACK);
    load_step(4); step();
    en = 1'b1;
    plan(5, "run_enfall", 4);
    step(); load_step(7); repeat (3) step();
    en = 1'b0;
    plan_idle(2, "enfall", 7);
    mark(1, B_ACK);
    step(); step();

    // Reset asserted mid-PEND while pix_en and ms_tick are high
    en = 1'b1;
    plan(4, "run_prerst", 7);
    step(); load_step(6); repeat (2) step();
    #2;
    rst = 1'b0;
    #1;
    check("midrst.strobes", 32'({pix_en, ms_tick, unit_tick, unit_ack}), 32'd0);
    check("midrst.unit_ms_cur", 32'(unit_ms_cur), 32'(UNIT_DEFAULT));
    en = 1'b0;
    @(negedge clk_in);
    rst = 1'b1;
    plan_idle(3, "post_midrst", 3);
    repeat (3) step();
    en = 1'b1;
    plan(13, "run_postrst", 3);
    mark(12, B_UNIT);
    repeat (13) step();
    en = 1'b0;
    plan_idle(1, "end", 3);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_morse_tick_scheduler
